// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch front end: reset vector,
// canonical NOP, fetch FSM encoding and the instruction buffer entry layout.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, instruction}; registered head,
// synchronous clear that wins over push and pop.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clr) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push)
                wr_ptr <= ~wr_ptr;
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

    // Storage carries no reset; consumers qualify the head with count.
    always_ff @(posedge clk) begin
        if (do_push && !clr)
            mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request engine feeding a
// two-entry buffer, with redirect flush and a sticky misaligned-target halt.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  req_addr, req_addr_nxt;
    logic         err, err_nxt;
    logic         fifo_push, fifo_clr, fifo_pop;
    logic [1:0]   count;
    logic         head_valid;
    logic         misaligned;
    fetch_entry_t head;

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data ({req_addr, imem_rsp_data}),
        .pop       (fifo_pop),
        .head      (head),
        .count     (count)
    );

    assign misaligned     = redirect_pc[1:0] != 2'b00;
    assign head_valid     = count != 2'd0;
    // Gating with rst_n keeps the request quiet while reset is held.
    assign imem_req_valid = rst_n && (state == S_REQ) && (count < DEPTH) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign instr_valid    = head_valid;
    assign instruction    = head_valid ? head.instr : NOP_INSTR;
    assign instr_pc       = head_valid ? head.pc : 32'h0000_0000;
    assign pc_plus4       = instr_pc + 32'd4;
    assign fifo_pop       = head_valid && instr_ready;
    assign misalign_err   = err;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_addr_nxt = req_addr;
        err_nxt      = err;
        fifo_push    = 1'b0;
        fifo_clr     = 1'b0;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    fifo_clr = 1'b1;
                    pc_nxt   = redirect_pc;
                    if (misaligned) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_HALT;
                    end
                end else if (imem_req_valid && imem_req_ready) begin
                    pc_nxt       = pc + 32'd4;
                    req_addr_nxt = pc;
                    state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fifo_clr = 1'b1;
                    pc_nxt   = redirect_pc;
                    err_nxt  = err | misaligned;
                    if (imem_rsp_valid)
                        state_nxt = misaligned ? S_HALT : S_REQ;
                    else
                        state_nxt = S_FLUSH;
                end else if (imem_rsp_valid) begin
                    fifo_push = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_FLUSH: begin
                if (redirect_valid) begin
                    fifo_clr = 1'b1;
                    pc_nxt   = redirect_pc;
                    err_nxt  = err | misaligned;
                end
                // A pending misaligned redirect turns the flush into a halt.
                if (imem_rsp_valid)
                    state_nxt = err_nxt ? S_HALT : S_REQ;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            err   <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        req_addr <= req_addr_nxt;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Reference model: fetch PC, outstanding/discard flags, halt, and the buffer as queues.
    logic [31:0] m_pc, m_lat;
    logic        m_out, m_drop, m_halt, m_err;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];

    task automatic model_reset();
        m_pc = TB_RESET_PC; m_lat = '0;
        m_out = 0; m_drop = 0; m_halt = 0; m_err = 0;
        q_pc.delete(); q_ins.delete();
    endtask

    task automatic model_step(input logic acc, input logic rsp, input logic [31:0] rdata,
                              input logic ir, input logic rv, input logic [31:0] rpc);
        if (!m_halt) begin
            if (q_pc.size() > 0 && ir) begin
                void'(q_pc.pop_front());
                void'(q_ins.pop_front());
            end
            if (rv) begin
                q_pc.delete(); q_ins.delete();
                m_pc = rpc;
                if (rpc[1:0] != 2'b00) m_err = 1;
                if (m_out && !rsp) m_drop = 1;
                else begin m_out = 0; m_drop = 0; m_halt = m_err; end
            end else if (m_out && rsp) begin
                if (!m_drop) begin q_pc.push_back(m_lat); q_ins.push_back(rdata); end
                m_out = 0; m_drop = 0; m_halt = m_err;
            end else if (acc) begin
                m_lat = m_pc;
                m_pc  = m_pc + 32'd4;
                m_out = 1;
            end
        end
    endtask

    logic        mem_pend;
    logic [31:0] mem_addr;
    logic        rmem_pend;
    int          rmem_cnt;

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
        mem_pend = 0; rmem_pend = 0; rmem_cnt = 0;
        model_reset();
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, TB_RESET_PC);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instruction", instruction, NOP_INSTR);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_pc_plus4", pc_plus4, 4);
        chk("rst_misalign", misalign_err, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        #1;
        chk("rel_req_valid", imem_req_valid, 1);
        chk("rel_req_addr", imem_req_addr, TB_RESET_PC);
    endtask

    // One cycle against a single-cycle-latency memory; men=0 withholds the response.
    task automatic mem_cycle(input logic rr, input logic ir, input logic rv, input logic [31:0] rpc,
                             input logic men, output logic acc, output logic [31:0] aaddr,
                             output logic popd, output logic [31:0] ppc, output logic [31:0] pins);
        @(negedge clk);
        imem_req_ready = rr; instr_ready = ir; redirect_valid = rv; redirect_pc = rpc;
        imem_rsp_valid = men && mem_pend;
        imem_rsp_data  = word_at(mem_addr);
        #1;
        acc   = imem_req_valid && imem_req_ready;
        aaddr = imem_req_addr;
        popd  = instr_valid && instr_ready;
        ppc   = instr_pc;
        pins  = instruction;
        if (imem_rsp_valid) mem_pend = 0;
        if (acc) begin mem_pend = 1; mem_addr = aaddr; end
    endtask

    typedef struct {
        logic        rr, rsp;
        logic [31:0] rdata;
        logic        ir, rv;
        logic [31:0] rpc;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ins, e_pc, e_p4;
        logic        e_err;
    } vec_t;

    vec_t vt[18];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc, popd, got, mis;
        logic [31:0] aaddr, ppc, pins;
        logic [31:0] addrs[2];
        logic        rr, ir, rv, rsp, e_rv;
        logic [31:0] rpc, rdata;
        int          n, halt_cnt;

        vt[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 32'h93,        1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h93,        32'h0,         32'h4, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h8,         1'b1, 32'h93,        32'h0,         32'h4, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 32'hDEAD,      1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC, 1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 32'h1111_0013, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h1111_0013, 32'hFFFF_FFFC, 32'h0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 32'h2222_0013, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h1111_0013, 32'hFFFF_FFFC, 32'h0, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h1111_0013, 32'hFFFF_FFFC, 32'h0, 1'b0};
        vt[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 32'h1111_0013, 32'hFFFF_FFFC, 32'h0, 1'b0};
        vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h2222_0013, 32'h0,         32'h4, 1'b0};
        vt[12] = '{1'b0, 1'b1, 32'hBAD,       1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h102,       1'b0, 32'h4,         1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b0};
        vt[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h102,       1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b1};
        vt[16] = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 32'h200,       1'b0, 32'h102,       1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b1};
        vt[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 32'h102,       1'b0, NOP_INSTR,     32'h0,         32'h4, 1'b1};

        reset_dut();
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            imem_req_ready = vt[i].rr; imem_rsp_valid = vt[i].rsp; imem_rsp_data = vt[i].rdata;
            instr_ready = vt[i].ir; redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            #1;
            chk($sformatf("v%0d_req_valid", i), imem_req_valid, vt[i].e_rv);
            chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].e_addr);
            chk($sformatf("v%0d_instr_valid", i), instr_valid, vt[i].e_iv);
            chk($sformatf("v%0d_instruction", i), instruction, vt[i].e_ins);
            chk($sformatf("v%0d_instr_pc", i), instr_pc, vt[i].e_pc);
            chk($sformatf("v%0d_pc_plus4", i), pc_plus4, vt[i].e_p4);
            chk($sformatf("v%0d_misalign", i), misalign_err, vt[i].e_err);
        end

        // Stalled decoder: two requests fill the buffer, then drain back-to-back.
        reset_dut();
        n = 0;
        addrs[0] = 32'hFFFF_FFFF; addrs[1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            mem_cycle(1, 0, 0, 0, 1, acc, aaddr, popd, ppc, pins);
            if (acc) begin
                if (n < 2) addrs[n] = aaddr;
                n++;
            end
        end
        chk("stall_req_count", n, 2);
        chk("stall_addr0", addrs[0], 32'h0);
        chk("stall_addr1", addrs[1], 32'h4);
        chk("stall_req_held", imem_req_valid, 0);
        mem_cycle(0, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
        chk("drain0_pop", popd, 1);
        chk("drain0_pc", ppc, 32'h0);
        chk("drain0_ins", pins, word_at(32'h0));
        mem_cycle(0, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
        chk("drain1_pop", popd, 1);
        chk("drain1_pc", ppc, 32'h4);
        chk("drain1_ins", pins, word_at(32'h4));

        // Redirect while the request for 8 is outstanding.
        reset_dut();
        got = 0;
        for (int i = 0; i < 20; i++) begin
            mem_cycle(1, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
            if (acc && aaddr == 32'h8) begin got = 1; break; end
        end
        chk("flush_reached_8", got, 1);
        mem_cycle(1, 1, 1, 32'h100, 0, acc, aaddr, popd, ppc, pins);
        chk("flush_no_req_on_redirect", acc, 0);
        mem_cycle(0, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
        chk("flush_buf_empty", instr_valid, 0);
        mem_cycle(1, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
        chk("flush_dropped", instr_valid, 0);
        chk("flush_next_req", acc, 1);
        chk("flush_next_addr", aaddr, 32'h100);

        // Reset while waiting; a late response after release must be ignored.
        reset_dut();
        mem_cycle(1, 0, 0, 0, 1, acc, aaddr, popd, ppc, pins);
        chk("late_first_acc", acc, 1);
        reset_dut();
        @(negedge clk);
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hBAD0_BAD0;
        #1;
        chk("late_req_valid", imem_req_valid, 1);
        chk("late_req_addr", imem_req_addr, TB_RESET_PC);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            mem_cycle(1, 1, 0, 0, 1, acc, aaddr, popd, ppc, pins);
            if (i == 0) chk("late_ignored", instr_valid, 0);
            if (popd) begin
                chk("late_first_pc", ppc, TB_RESET_PC);
                chk("late_first_ins", pins, word_at(TB_RESET_PC));
                got = 1;
                break;
            end
        end
        chk("late_got_instr", got, 1);

        // Randomized traffic against the reference model.
        reset_dut();
        halt_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rr  = ($urandom % 10) < 7;
            ir  = ($urandom % 4) != 0;
            rv  = ($urandom % 12) == 0;
            mis = ($urandom % 10) == 0;
            rpc = ($urandom % 5 == 0) ? 32'hFFFF_FFF8 : $urandom;
            rpc[1:0] = mis ? 2'b01 : 2'b00;
            rdata = $urandom;
            if (rmem_pend && rmem_cnt == 0) rsp = 1;
            else if (!rmem_pend && ($urandom % 16) == 0) rsp = 1;
            else rsp = 0;
            imem_req_ready = rr; instr_ready = ir; redirect_valid = rv; redirect_pc = rpc;
            imem_rsp_valid = rsp; imem_rsp_data = rdata;
            #1;
            e_rv = !m_halt && !m_out && (q_pc.size() < 2) && !rv;
            chk($sformatf("rnd%0d_req_valid", cyc), imem_req_valid, e_rv);
            chk($sformatf("rnd%0d_req_addr", cyc), imem_req_addr, m_pc);
            chk($sformatf("rnd%0d_instr_valid", cyc), instr_valid, q_pc.size() != 0);
            chk($sformatf("rnd%0d_instruction", cyc), instruction, (q_ins.size() != 0) ? q_ins[0] : NOP_INSTR);
            chk($sformatf("rnd%0d_instr_pc", cyc), instr_pc, (q_pc.size() != 0) ? q_pc[0] : 32'h0);
            chk($sformatf("rnd%0d_pc_plus4", cyc), pc_plus4, ((q_pc.size() != 0) ? q_pc[0] : 32'h0) + 32'd4);
            chk($sformatf("rnd%0d_misalign", cyc), misalign_err, m_err);
            acc = imem_req_valid && imem_req_ready;
            model_step(e_rv && rr, rsp, rdata, ir, rv, rpc);
            if (rmem_pend && rmem_cnt == 0) rmem_pend = 0;
            else if (rmem_pend) rmem_cnt--;
            if (acc) begin rmem_pend = 1; rmem_cnt = int'($urandom % 3); end
            if (m_halt) halt_cnt++;
            if (halt_cnt > 4) begin
                reset_dut();
                halt_cnt = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries; only 2 supported.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address (= PC register).
REQ-008 imem_rsp_valid  input  1  instruction word returned; never earlier than the cycle after acceptance.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 instr_valid  output  1  buffer head holds an instruction for the decoder.
REQ-011 instr_ready  input  1  decoder consumes the head this cycle.
REQ-012 instruction  output  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
REQ-013 instr_pc  output  32  address of the head instruction.
REQ-014 pc_plus4  output  32  instr_pc + 4, modulo 2^32.
REQ-015 redirect_valid  input  1  control-flow change (jal target from execute).
REQ-016 redirect_pc  input  32  new fetch address.
REQ-017 misalign_err  output  1  sticky: a redirect to a non-word-aligned address was seen.

Function
REQ-018 States: S_REQ (may issue), S_WAIT (one request outstanding), S_FLUSH (outstanding response to be discarded), S_HALT (error).
REQ-019 At most one request outstanding; imem_req_valid=1 only in S_REQ when (buffer count) < 2 and redirect_valid=0.
REQ-020 S_REQ: on imem_req_valid && imem_req_ready, PC <= PC+4 (wraps 32'hFFFF_FFFC -> 0), latch request address, go S_WAIT.
REQ-021 S_WAIT: on imem_rsp_valid, push {imem_rsp_data, latched address} into buffer, go S_REQ.
REQ-022 Pushed instruction appears at instruction/instr_valid the cycle after imem_rsp_valid (registered buffer).
REQ-023 Pop on instr_valid && instr_ready; push and pop in the same cycle both take effect, count unchanged.
REQ-024 Buffer full (count 2): no new request; outstanding response always has space by REQ-019.
REQ-025 Redirect (redirect_valid=1, redirect_pc[1:0]=0): buffer cleared next cycle, PC <= redirect_pc, no request issued that cycle.
REQ-026 Redirect in S_WAIT without imem_rsp_valid: go S_FLUSH; with imem_rsp_valid same cycle: response dropped, go S_REQ.
REQ-027 S_FLUSH: next imem_rsp_valid discarded, go S_REQ; another redirect in S_FLUSH updates PC only, stays S_FLUSH.
REQ-028 Redirect coincident with a pop: the pop completes (decoder took head), then buffer is cleared.
REQ-029 Redirect with redirect_pc[1:0]!=0: misalign_err <= 1, buffer cleared, go S_HALT (S_FLUSH first if a response is outstanding); S_HALT issues nothing until reset.
REQ-030 imem_rsp_valid in S_REQ or S_HALT (no outstanding request) is ignored.

Reset
REQ-031 While rst_n=0: PC=RESET_PC, state S_REQ, buffer empty, misalign_err=0, imem_req_valid=0, instr_valid=0, instruction=NOP, instr_pc=0, pc_plus4=4.
REQ-032 Reset assertion mid-request abandons the outstanding response; first request, address RESET_PC, is driven in the first cycle after rst_n rises.

Structure
REQ-033 Shared package riscv_pkg holds RESET_PC default, NOP_INSTR (32'h0000_0013), and the fetch state encoding.
REQ-034 Buffer is sub-module fetch_fifo (2-entry, 64-bit entry {pc, instruction}, synchronous clear, count output).

Verification
REQ-035 Reset release, imem_req_ready=1, 1-cycle memory returning 32'h0000_0093 at 0 -> req addr 0 at cycle 1, instr_valid with instr_pc=0, pc_plus4=4 at cycle 3.
REQ-036 instr_ready=0 for 10 cycles -> exactly 2 requests (addr 0, 4), imem_req_valid then held 0; release ready -> instr 0 then 4 popped back-to-back.
REQ-037 Redirect to 32'h0000_0100 while request for 8 outstanding -> response for 8 dropped, buffer empty, next request addr 32'h100.
REQ-038 Redirect to 32'h0000_0102 -> misalign_err=1 next cycle, no further imem_req_valid until rst_n toggled.
REQ-039 Redirect to 32'hFFFF_FFFC -> requests at 32'hFFFF_FFFC then 32'h0000_0000; pc_plus4 of first = 0.
REQ-040 rst_n asserted in S_WAIT, late response arrives after release -> ignored; first accepted instruction has instr_pc=RESET_PC.
